hilo_seq_ctrl: RTL

Multi-cycle sequencer in front of the HI/LO multiply/divide register block (div_mult_reg). It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issues from decode and latches the operands. It models the arithmetic latency with a down-counter, then drives a single-cycle write strobe with op/sin/operands to the register block. While an operation is in flight it back-pressures new issues and stalls MFHI/MFLO reads.

---
 rtl/hilo_seq_ctrl_pkg.sv | 40 ++++
 rtl/hilo_seq_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/hilo_seq_ctrl_pkg.sv
// Shared types for the HI/LO sequencer: decode op codes, FSM states and the
// div_mult_reg op encoding.
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_MTHI  = 3'd0,
    OP_MTLO  = 3'd1,
    OP_MULT  = 3'd2,
    OP_MULTU = 3'd3,
    OP_DIV   = 3'd4,
    OP_DIVU  = 3'd5
  } hilo_op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_COMMIT   = 2'd3
  } hilo_state_t;

  localparam logic [1:0] DM_MTHI = 2'b00;
  localparam logic [1:0] DM_MTLO = 2'b01;
  localparam logic [1:0] DM_MUL  = 2'b10;
  localparam logic [1:0] DM_DIV  = 2'b11;

  // Map a decode op onto the register-block op field.
  function automatic logic [1:0] dm_op_of(hilo_op_t op);
    case (op)
      OP_MTHI:           return DM_MTHI;
      OP_MTLO:           return DM_MTLO;
      OP_MULT, OP_MULTU: return DM_MUL;
      default:           return DM_DIV;
    endcase
  endfunction

  function automatic logic is_signed_op(hilo_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_seq_ctrl.sv
// Multi-cycle sequencer feeding the HI/LO register block: latches an issued op,
// waits out the arithmetic latency, then pulses one write strobe.
// Optional macro HILO_DIV0_TRAP_EN: divide-by-zero is dropped and flagged.
module hilo_seq_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [2:0]  issue_op,
  input  logic [31:0] issue_rs,
  input  logic [31:0] issue_rt,
  output logic        issue_ready,
  input  logic        mf_req,
  output logic        mf_stall,
  output logic        busy,
  output logic        dm_write_en,
  output logic [1:0]  dm_op,
  output logic        dm_sin,
  output logic [31:0] dm_in_1,
  output logic [31:0] dm_in_2
`ifdef HILO_DIV0_TRAP_EN
  ,
  output logic        div0_flag
`endif
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

  hilo_state_t      state;
  logic [CNT_W-1:0] cnt;
  hilo_op_t         op_q;
  logic [31:0]      rs_q;
  logic [31:0]      rt_q;

  hilo_op_t op_in;
  logic     accept;
  logic     legal;
  logic     take;

  assign op_in  = hilo_op_t'(issue_op);
  assign accept = issue_valid && (state == ST_IDLE);
  assign legal  = (issue_op <= 3'd5);

`ifdef HILO_DIV0_TRAP_EN
  logic div0;
  assign div0 = ((op_in == OP_DIV) || (op_in == OP_DIVU)) && (issue_rt == 32'd0);
  assign take = accept && legal && !div0;
`else
  assign take = accept && legal;
`endif

  // Sequencer state, latency counter and operand latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= OP_MTHI;
      rs_q  <= '0;
      rt_q  <= '0;
`ifdef HILO_DIV0_TRAP_EN
      div0_flag <= 1'b0;
`endif
    end else begin
`ifdef HILO_DIV0_TRAP_EN
      div0_flag <= accept && legal && div0;
`endif
      case (state)
        ST_IDLE: begin
          if (take) begin
            op_q <= op_in;
            rs_q <= issue_rs;
            rt_q <= issue_rt;
            case (op_in)
              OP_MTHI, OP_MTLO: state <= ST_COMMIT;
              OP_MULT, OP_MULTU: begin
                cnt   <= CNT_W'(MULT_CYCLES - 1);
                state <= ST_MUL_WAIT;
              end
              default: begin
                cnt   <= CNT_W'(DIV_CYCLES - 1);
                state <= ST_DIV_WAIT;
              end
            endcase
          end
        end
        ST_MUL_WAIT, ST_DIV_WAIT: begin
          if (cnt == '0) state <= ST_COMMIT;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (state != ST_IDLE);
  assign issue_ready = (state == ST_IDLE);
  assign mf_stall    = mf_req && busy;
  assign dm_write_en = (state == ST_COMMIT);

  // Register-block payload is held from the latch while busy, zero in IDLE.
  always_comb begin
    dm_op   = 2'b00;
    dm_sin  = 1'b0;
    dm_in_1 = 32'd0;
    dm_in_2 = 32'd0;
    if (busy) begin
      dm_op   = dm_op_of(op_q);
      dm_sin  = is_signed_op(op_q);
      dm_in_1 = rs_q;
      dm_in_2 = rt_q;
    end
  end

endmodule
